// File: rtl/fft_stream_framer_if.sv
// Streaming bus carrying one complex sample per beat with Avalon-ST framing.
interface fft_stream_framer_if #(
    parameter int unsigned W = 14
);
    logic                valid;
    logic                sop;
    logic                eop;
    logic                ready;
    logic signed [W-1:0] re;
    logic signed [W-1:0] im;

    modport master (output valid, sop, eop, re, im, input ready);
    modport slave  (input valid, sop, eop, re, im, output ready);
endinterface

// File: rtl/fft_stream_framer.sv
// Frames a continuous ADC sample stream into N-point FFT sink frames and
// computes per-bin power from the FFT source stream.
module fft_stream_framer #(
    parameter int unsigned DATA_W    = 14,
    parameter int unsigned PTS_LOG2  = 10,
    parameter int unsigned FIFO_LOG2 = 4,
    parameter int unsigned SRC_W     = 25,
    parameter int unsigned HOLD_CYC  = 10
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic signed [DATA_W-1:0] in_signal,
    input  logic                     in_valid,
    output logic                     fft_reset_n,
    fft_stream_framer_if.master      sink,
    output logic [PTS_LOG2:0]        fft_pts,
    fft_stream_framer_if.slave       source,
    output logic [2*SRC_W:0]         pwr,
    output logic                     pwr_valid,
    output logic                     pwr_sop,
    output logic                     pwr_eop,
    output logic                     overflow,
    output logic [15:0]              frame_cnt
);
    localparam int unsigned DEPTH  = 1 << FIFO_LOG2;
    localparam int unsigned PTR_W  = FIFO_LOG2;
    localparam int unsigned CNT_W  = FIFO_LOG2 + 1;
    localparam int unsigned HOLD_W = $clog2(HOLD_CYC + 1);
    localparam int unsigned PTS_W  = PTS_LOG2 + 1;
    localparam int unsigned PROD_W = 2 * SRC_W;
    localparam int unsigned PWR_W  = 2 * SRC_W + 1;
    localparam logic [PTS_LOG2-1:0] IDX_LAST = '1;

    typedef enum logic [1:0] {ST_HOLD, ST_IDLE, ST_STREAM} state_t;

    state_t                    state;
    state_t                    state_nxt;
    logic [HOLD_W-1:0]         hold_cnt;
    logic signed [DATA_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]          wr_ptr;
    logic [PTR_W-1:0]          rd_ptr;
    logic [CNT_W-1:0]          count;
    logic [CNT_W-1:0]          cnt_nxt;
    logic [PTS_LOG2-1:0]       idx;
    logic                      full;
    logic                      empty;
    logic                      xfer;
    logic                      wr;
    logic                      drop;
    logic [PROD_W-1:0]         re_sq;
    logic [PROD_W-1:0]         im_sq;
    logic                      s1_valid;
    logic                      s1_sop;
    logic                      s1_eop;

    assign fft_pts      = PTS_W'(1 << PTS_LOG2);
    assign source.ready = 1'b1;

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_HOLD;
        else          state <= state_nxt;
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_HOLD:   if (hold_cnt == HOLD_W'(HOLD_CYC - 1)) state_nxt = ST_IDLE;
            ST_IDLE:   if (!empty) state_nxt = ST_STREAM;
            ST_STREAM: if (xfer && idx == IDX_LAST && cnt_nxt == '0) state_nxt = ST_IDLE;
            default:   state_nxt = ST_HOLD;
        endcase
    end

    // FSM outputs: core reset and sink framing, all derived from registered state
    always_comb begin
        fft_reset_n = 1'b1;
        sink.valid  = 1'b0;
        sink.sop    = 1'b0;
        sink.eop    = 1'b0;
        sink.re     = mem[rd_ptr];
        sink.im     = '0;
        if (state == ST_HOLD) fft_reset_n = 1'b0;
        if (state == ST_STREAM && !empty) begin
            sink.valid = 1'b1;
            sink.sop   = (idx == '0);
            sink.eop   = (idx == IDX_LAST);
        end
    end

    // FIFO control: a full FIFO still accepts a write when the same cycle pops
    always_comb begin
        full    = (count == CNT_W'(DEPTH));
        empty   = (count == '0);
        xfer    = sink.valid && sink.ready;
        wr      = in_valid && (state != ST_HOLD) && (!full || xfer);
        drop    = in_valid && (state != ST_HOLD) && full && !xfer;
        cnt_nxt = count + CNT_W'(wr) - CNT_W'(xfer);
    end

    // Core reset hold counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)              hold_cnt <= '0;
        else if (state == ST_HOLD) hold_cnt <= hold_cnt + HOLD_W'(1);
    end

    // Input FIFO storage and pointers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr) begin
                mem[wr_ptr] <= in_signal;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (xfer) rd_ptr <= rd_ptr + PTR_W'(1);
            count <= cnt_nxt;
        end
    end

    // Frame index, completed-frame counter and sticky drop flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx       <= '0;
            frame_cnt <= '0;
            overflow  <= 1'b0;
        end else begin
            if (xfer) idx <= idx + PTS_LOG2'(1);
            if (xfer && idx == IDX_LAST) frame_cnt <= frame_cnt + 16'd1;
            if (drop) overflow <= 1'b1;
        end
    end

    // Power stage 1: squares of real and imaginary parts
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            re_sq    <= '0;
            im_sq    <= '0;
            s1_valid <= 1'b0;
            s1_sop   <= 1'b0;
            s1_eop   <= 1'b0;
        end else begin
            if (source.valid) begin
                re_sq <= PROD_W'(source.re) * PROD_W'(source.re);
                im_sq <= PROD_W'(source.im) * PROD_W'(source.im);
            end
            s1_valid <= source.valid;
            s1_sop   <= source.sop;
            s1_eop   <= source.eop;
        end
    end

    // Power stage 2: full-width unsigned sum, held while no new bin arrives
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwr       <= '0;
            pwr_valid <= 1'b0;
            pwr_sop   <= 1'b0;
            pwr_eop   <= 1'b0;
        end else begin
            if (s1_valid) pwr <= PWR_W'(re_sq) + PWR_W'(im_sq);
            pwr_valid <= s1_valid;
            pwr_sop   <= s1_sop;
            pwr_eop   <= s1_eop;
        end
    end
endmodule

// File: tb/tb_fft_stream_framer.sv
// Directed bench for fft_stream_framer with N=8, FIFO depth 4, 10-cycle hold.
module tb_fft_stream_framer;
    localparam int unsigned DATA_W    = 14;
    localparam int unsigned PTS_LOG2  = 3;
    localparam int unsigned FIFO_LOG2 = 2;
    localparam int unsigned SRC_W     = 25;
    localparam int unsigned HOLD_CYC  = 10;

    logic                     clk = 1'b0;
    logic                     reset_n = 1'b0;
    logic signed [DATA_W-1:0] in_signal = '0;
    logic                     in_valid = 1'b0;
    logic                     fft_reset_n;
    logic [PTS_LOG2:0]        fft_pts;
    logic [2*SRC_W:0]         pwr;
    logic                     pwr_valid;
    logic                     pwr_sop;
    logic                     pwr_eop;
    logic                     overflow;
    logic [15:0]              frame_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int mon_re[$];
    int mon_sop[$];
    int mon_eop[$];
    int mon_cyc[$];

    fft_stream_framer_if #(.W(DATA_W)) sink ();
    fft_stream_framer_if #(.W(SRC_W))  source ();

    fft_stream_framer #(
        .DATA_W(DATA_W), .PTS_LOG2(PTS_LOG2), .FIFO_LOG2(FIFO_LOG2),
        .SRC_W(SRC_W), .HOLD_CYC(HOLD_CYC)
    ) dut (
        .clk(clk), .reset_n(reset_n), .in_signal(in_signal), .in_valid(in_valid),
        .fft_reset_n(fft_reset_n), .sink(sink), .fft_pts(fft_pts), .source(source),
        .pwr(pwr), .pwr_valid(pwr_valid), .pwr_sop(pwr_sop), .pwr_eop(pwr_eop),
        .overflow(overflow), .frame_cnt(frame_cnt)
    );

    // Clock
    always #5 clk = ~clk;

    // Cycle counter
    always @(posedge clk) cyc <= cyc + 1;

    // Record each sink transfer half a cycle before the edge that commits it
    always @(negedge clk) begin
        if (reset_n && sink.valid && sink.ready) begin
            mon_re.push_back(int'(sink.re));
            mon_sop.push_back(int'(sink.sop));
            mon_eop.push_back(int'(sink.eop));
            mon_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mon_clear();
        mon_re.delete();
        mon_sop.delete();
        mon_eop.delete();
        mon_cyc.delete();
    endtask

    // Count edges until the core reset releases, bounded
    task automatic wait_hold(output int n, output int early_valid);
        n = 0;
        early_valid = 0;
        while (!fft_reset_n && n < 20) begin
            if (sink.valid) early_valid++;
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        int ev;
        int nxt;
        int stalls;
        logic [63:0] exp_big;

        sink.ready   = 1'b1;
        source.valid = 1'b0;
        source.sop   = 1'b0;
        source.eop   = 1'b0;
        source.re    = '0;
        source.im    = '0;

        // Reset state
        tick();
        tick();
        check("rst_fft_reset_n", 64'(fft_reset_n), 64'd0);
        check("rst_sink_valid", 64'(sink.valid), 64'd0);
        check("rst_sink_real", 64'(sink.re), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        check("rst_pwr", 64'(pwr), 64'd0);
        check("rst_pwr_valid", 64'(pwr_valid), 64'd0);
        check("fft_pts", 64'(fft_pts), 64'd8);
        check("sink_imag", 64'(sink.im), 64'd0);
        check("source_ready", 64'(source.ready), 64'd1);

        // Hold phase with samples arriving that must be discarded
        in_valid  = 1'b1;
        in_signal = DATA_W'(119);
        reset_n   = 1'b1;
        wait_hold(n, ev);
        in_valid = 1'b0;
        check("hold_cycles", 64'(n), 64'd10);
        check("hold_no_valid", 64'(ev), 64'd0);
        check("hold_fft_reset_n", 64'(fft_reset_n), 64'd1);
        tick();
        tick();
        tick();
        check("hold_discard_valid", 64'(sink.valid), 64'd0);
        check("hold_discard_ovf", 64'(overflow), 64'd0);

        // Two back-to-back frames of samples 1..16
        mon_clear();
        nxt = 1;
        for (int c = 0; c < 50 && mon_re.size() < 16; c++) begin
            if (nxt <= 16) begin
                in_valid  = 1'b1;
                in_signal = DATA_W'(nxt);
                nxt++;
            end else begin
                in_valid = 1'b0;
            end
            tick();
        end
        in_valid = 1'b0;
        check("f2_count", 64'(mon_re.size()), 64'd16);
        for (int i = 0; i < mon_re.size(); i++) begin
            check("f2_beat", 64'({mon_re[i], mon_sop[i], mon_eop[i]}),
                  64'({i + 1, int'(i == 0 || i == 8), int'(i == 7 || i == 15)}));
        end
        if (mon_cyc.size() >= 9) check("f2_no_gap", 64'(mon_cyc[8] - mon_cyc[7]), 64'd1);
        check("f2_frame_cnt", 64'(frame_cnt), 64'd2);
        check("f2_overflow", 64'(overflow), 64'd0);
        tick();

        // Backpressure for 3 clocks while sample 5 sits at the head
        mon_clear();
        nxt = 1;
        stalls = 0;
        for (int c = 0; c < 60 && mon_re.size() < 8; c++) begin
            if (!sink.ready) begin
                check("bp_hold_real", 64'(sink.re), 64'd5);
                check("bp_hold_valid", 64'(sink.valid), 64'd1);
            end
            if (sink.valid && sink.re == DATA_W'(5) && stalls < 3) begin
                sink.ready = 1'b0;
                stalls++;
            end else begin
                sink.ready = 1'b1;
            end
            if (sink.ready && nxt <= 8) begin
                in_valid  = 1'b1;
                in_signal = DATA_W'(nxt);
                nxt++;
            end else begin
                in_valid = 1'b0;
            end
            tick();
        end
        in_valid   = 1'b0;
        sink.ready = 1'b1;
        check("bp_stalls", 64'(stalls), 64'd3);
        check("bp_count", 64'(mon_re.size()), 64'd8);
        for (int i = 0; i < mon_re.size(); i++) begin
            check("bp_beat", 64'({mon_re[i], mon_sop[i], mon_eop[i]}),
                  64'({i + 1, int'(i == 0), int'(i == 7)}));
        end
        check("bp_frame_cnt", 64'(frame_cnt), 64'd3);
        tick();

        // Power path: -3+4j with sop, then max-negative, then max-pos/max-neg
        source.valid = 1'b1;
        source.sop   = 1'b1;
        source.re    = SRC_W'(-3);
        source.im    = SRC_W'(4);
        tick();
        source.valid = 1'b0;
        source.sop   = 1'b0;
        check("pwr_lat1_valid", 64'(pwr_valid), 64'd0);
        tick();
        check("pwr_small", 64'(pwr), 64'd25);
        check("pwr_small_valid", 64'(pwr_valid), 64'd1);
        check("pwr_small_sop", 64'(pwr_sop), 64'd1);
        check("pwr_small_eop", 64'(pwr_eop), 64'd0);
        tick();
        check("pwr_idle_valid", 64'(pwr_valid), 64'd0);
        check("pwr_idle_hold", 64'(pwr), 64'd25);
        source.valid = 1'b1;
        source.re    = {1'b1, {(SRC_W-1){1'b0}}};
        source.im    = {1'b1, {(SRC_W-1){1'b0}}};
        tick();
        source.eop   = 1'b1;
        source.re    = {1'b0, {(SRC_W-1){1'b1}}};
        tick();
        source.valid = 1'b0;
        source.eop   = 1'b0;
        check("pwr_maxneg", 64'(pwr), 64'd1 << 49);
        check("pwr_maxneg_eop", 64'(pwr_eop), 64'd0);
        tick();
        exp_big = (64'd1 << 49) - (64'd1 << 25) + 64'd1;
        check("pwr_mixed", 64'(pwr), exp_big);
        check("pwr_mixed_eop", 64'(pwr_eop), 64'd1);
        tick();

        // Overflow: ready low, six pushes into a depth-4 FIFO
        sink.ready = 1'b0;
        for (int k = 21; k <= 24; k++) begin
            in_valid  = 1'b1;
            in_signal = DATA_W'(k);
            tick();
        end
        check("ovf_not_yet", 64'(overflow), 64'd0);
        for (int k = 25; k <= 26; k++) begin
            in_valid  = 1'b1;
            in_signal = DATA_W'(k);
            tick();
        end
        in_valid = 1'b0;
        check("ovf_set", 64'(overflow), 64'd1);
        check("ovf_head_real", 64'(sink.re), 64'd21);
        check("ovf_head_sop", 64'(sink.sop), 64'd1);
        mon_clear();
        sink.ready = 1'b1;
        for (int c = 0; c < 10; c++) tick();
        check("ovf_drain_count", 64'(mon_re.size()), 64'd4);
        for (int i = 0; i < mon_re.size(); i++) begin
            check("ovf_drain_real", 64'(mon_re[i]), 64'(21 + i));
        end
        check("ovf_sticky", 64'(overflow), 64'd1);

        // Reset in the middle of a frame at index 4
        sink.ready = 1'b0;
        in_valid   = 1'b1;
        in_signal  = DATA_W'(30);
        tick();
        in_valid = 1'b0;
        tick();
        check("mid_valid", 64'(sink.valid), 64'd1);
        check("mid_real", 64'(sink.re), 64'd30);
        check("mid_sop", 64'(sink.sop), 64'd0);
        reset_n = 1'b0;
        #1;
        check("arst_fft_reset_n", 64'(fft_reset_n), 64'd0);
        check("arst_sink_valid", 64'(sink.valid), 64'd0);
        check("arst_sink_real", 64'(sink.re), 64'd0);
        check("arst_overflow", 64'(overflow), 64'd0);
        check("arst_frame_cnt", 64'(frame_cnt), 64'd0);
        check("arst_pwr", 64'(pwr), 64'd0);
        tick();
        tick();
        reset_n = 1'b1;
        wait_hold(n, ev);
        check("arst_hold_cycles", 64'(n), 64'd10);
        mon_clear();
        sink.ready = 1'b1;
        in_valid   = 1'b1;
        in_signal  = DATA_W'(40);
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 10 && mon_re.size() < 1; c++) tick();
        check("arst_first_count", 64'(mon_re.size()), 64'd1);
        if (mon_re.size() >= 1) begin
            check("arst_first_real", 64'(mon_re[0]), 64'd40);
            check("arst_first_sop", 64'(mon_sop[0]), 64'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fft_stream_framer.md
FFT_STREAM_FRAMER -- requirements
Module: fft_stream_framer

Interface
REQ-001 Parameters SHALL be: DATA_W, default 14, input sample width; PTS_LOG2, default 10, log2 of FFT frame length N; FIFO_LOG2, default 4, log2 of input FIFO depth D; SRC_W, default 25, FFT source component width; HOLD_CYC, default 10, FFT core reset hold in clocks.
REQ-002 clk  input  1  single clock, all logic rising-edge.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 in_signal  input  DATA_W  signed ADC sample; in_valid  input  1  sample present.
REQ-005 fft_reset_n  output  1  reset to FFT core, active-low.
REQ-006 sink_valid, sink_sop, sink_eop  output  1 each  Avalon-ST framing to FFT sink; sink_ready  input  1  FFT backpressure, ready-latency 0.
REQ-007 sink_real, sink_imag  output  DATA_W  sample to FFT; fft_pts  output  PTS_LOG2+1  frame length.
REQ-008 source_valid, source_sop, source_eop  input  1 each; source_real, source_imag  input  SRC_W signed  FFT output bins.
REQ-009 pwr  output  2*SRC_W+1  unsigned bin power; pwr_valid, pwr_sop, pwr_eop  output  1 each.
REQ-010 overflow  output  1  sticky input-drop flag; frame_cnt  output  16  completed input frames.

Function
REQ-011 fft_pts SHALL be constant N = 2^PTS_LOG2; sink_imag SHALL be constant 0; sink_real SHALL be the FIFO head sample.
REQ-012 States SHALL be HOLD, IDLE, STREAM; reset enters HOLD.
REQ-013 HOLD: fft_reset_n=0 for exactly HOLD_CYC clocks after reset_n deassertion, then fft_reset_n=1 and go IDLE.
REQ-014 In HOLD, in_valid samples SHALL be discarded without setting overflow.
REQ-015 IDLE -> STREAM SHALL occur on the first clock the FIFO is non-empty; index counter starts at 0.
REQ-016 sink_valid SHALL equal (state==STREAM && FIFO non-empty); a transfer is a cycle with sink_valid && sink_ready.
REQ-017 sink_sop SHALL be 1 while sink_valid and index==0; sink_eop SHALL be 1 while sink_valid and index==N-1.
REQ-018 Index SHALL increment per transfer, wrap N-1 -> 0; frame_cnt SHALL increment (wrapping at 2^16) on each eop transfer.
REQ-019 After an eop transfer the block SHALL remain in STREAM (back-to-back frames) if FIFO non-empty, else return to IDLE.
REQ-020 FIFO write SHALL occur when in_valid and (not full or a transfer pops the same cycle); read on transfer.
REQ-021 Earliest sink_valid for a sample accepted into an empty FIFO SHALL be the next clock (one-cycle latency).
REQ-022 in_valid with FIFO full and no same-cycle pop SHALL drop the sample and set overflow until reset; framing SHALL continue unaltered.
REQ-023 Sink outputs SHALL hold stable while sink_valid && !sink_ready.
REQ-024 Power path SHALL accept every source_valid cycle (source side never stalls).
REQ-025 Stage 1 SHALL register re*re and im*im (signed, 2*SRC_W each); stage 2 SHALL register their unsigned sum into pwr (2*SRC_W+1, no truncation).
REQ-026 pwr_valid/pwr_sop/pwr_eop SHALL be source_valid/sop/eop delayed exactly 2 clocks; pwr holds last value when pwr_valid=0.

Reset
REQ-027 reset_n low SHALL asynchronously force: state HOLD, fft_reset_n=0, FIFO empty, index 0, sink_valid/sop/eop=0, sink_real=0, pwr=0, pwr_valid/sop/eop=0, overflow=0, frame_cnt=0.
REQ-028 Reset asserted mid-frame SHALL abandon the partial frame; after release the first transfer SHALL carry sink_sop=1.

Verification (bench: PTS_LOG2=3, FIFO_LOG2=2, HOLD_CYC=10)
REQ-029 Release reset, in_valid=1 continuous -> fft_reset_n rises on clock 10; no sink_valid before; overflow stays 0 while sink_ready=1.
REQ-030 16 samples 1..16, sink_ready=1 -> two frames: sop with 1 and 9, eop with 8 and 16, no gap between frames, frame_cnt=2.
REQ-031 sink_ready=0 for 3 clocks mid-frame at value 5 -> sink_real=5, sink_valid=1 held; sequence resumes intact.
REQ-032 sink_ready=0, 6 samples pushed -> first 4 stored, samples 5 and 6 dropped, overflow=1 sticky.
REQ-033 source_real=-3, source_imag=4, source_valid=1 with sop -> 2 clocks later pwr=25, pwr_valid=1, pwr_sop=1; max-negative inputs give pwr=2^(2*SRC_W-1) with no wrap.
REQ-034 Assert reset_n low at index 4 of a frame -> all outputs per REQ-027 immediately; after hold, next transfer has sink_sop=1.
